// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet manager: slot record, sine table,
// fixed-point format and the spawn velocity scaler.
package bullet_pkg;

    localparam int FRAC_BITS = 4;

    typedef struct packed {
        logic               valid;
        logic [13:0]        x_fp;
        logic [13:0]        y_fp;
        logic signed [8:0]  vx;
        logic signed [8:0]  vy;
        logic [7:0]         life;
    } bullet_t;

    // round(64*sin(2*pi*k/64)), one full turn
    localparam logic signed [7:0] SIN_TABLE [64] = '{
        8'sd0,   8'sd6,   8'sd12,  8'sd19,  8'sd24,  8'sd30,  8'sd36,  8'sd41,
        8'sd45,  8'sd49,  8'sd53,  8'sd56,  8'sd59,  8'sd61,  8'sd63,  8'sd64,
        8'sd64,  8'sd64,  8'sd63,  8'sd61,  8'sd59,  8'sd56,  8'sd53,  8'sd49,
        8'sd45,  8'sd41,  8'sd36,  8'sd30,  8'sd24,  8'sd19,  8'sd12,  8'sd6,
        8'sd0,   -8'sd6,  -8'sd12, -8'sd19, -8'sd24, -8'sd30, -8'sd36, -8'sd41,
        -8'sd45, -8'sd49, -8'sd53, -8'sd56, -8'sd59, -8'sd61, -8'sd63, -8'sd64,
        -8'sd64, -8'sd64, -8'sd63, -8'sd61, -8'sd59, -8'sd56, -8'sd53, -8'sd49,
        -8'sd45, -8'sd41, -8'sd36, -8'sd30, -8'sd24, -8'sd19, -8'sd12, -8'sd6
    };

    // Velocity in 1/16 px: (trig*speed)>>>2, negated first when requested
    function automatic logic signed [8:0] scale_velocity(
        input logic signed [7:0] trig,
        input int                speed,
        input logic              negate
    );
        logic signed [15:0] prod;
        prod = 16'(trig) * 16'(speed);
        if (negate) begin
            prod = -prod;
        end
        return 9'(prod >>> 2);
    endfunction

endpackage

// File: rtl/bullet_manager_if.sv
// Ship/keyboard inputs and bullet outputs between the motion block and renderer.
interface bullet_manager_if #(
    parameter int NUM_BULLETS = 4
);
    logic [63:0]               keycode;
    logic [9:0]                ShipX;
    logic [9:0]                ShipY;
    logic [5:0]                ShipAngle;
    logic [NUM_BULLETS*10-1:0] BulletX;
    logic [NUM_BULLETS*10-1:0] BulletY;
    logic [NUM_BULLETS-1:0]    BulletValid;
    logic                      ShotFired;

    modport master (
        output keycode, ShipX, ShipY, ShipAngle,
        input  BulletX, BulletY, BulletValid, ShotFired
    );

    modport slave (
        input  keycode, ShipX, ShipY, ShipAngle,
        output BulletX, BulletY, BulletValid, ShotFired
    );
endinterface

// File: rtl/bullet_manager_trig_lut.sv
// Combinational sine/cosine lookup for a 6-bit heading.
module trig_lut
    import bullet_pkg::*;
(
    input  logic [5:0]        angle_i,
    output logic signed [7:0] sin_o,
    output logic signed [7:0] cos_o
);
    logic [5:0] cos_idx;

    // Quarter-turn offset wraps naturally in 6 bits
    assign cos_idx = angle_i + 6'd16;
    assign sin_o   = SIN_TABLE[angle_i];
    assign cos_o   = SIN_TABLE[cos_idx];
endmodule

// File: rtl/bullet_manager.sv
// Spawns bullets at the ship on a fire-key press and moves live bullets
// once per frame along their latched headings until expiry or off-screen.
module bullet_manager
    import bullet_pkg::*;
#(
    parameter int         NUM_BULLETS  = 4,
    parameter int         BULLET_SPEED = 4,
    parameter int         LIFETIME     = 60,
    parameter int         COOLDOWN     = 8,
    parameter logic [7:0] FIRE_KEY     = 8'h2C,
    parameter int         X_MAX        = 639,
    parameter int         Y_MAX        = 479
) (
    input logic             frame_clk,
    input logic             Reset_n,
    bullet_manager_if.slave bus
);
    logic [7:0]             key_hit;
    logic                   fire;
    logic                   press;
    logic                   spawn;
    logic                   fire_prev_q;
    logic                   shot_q;
    logic [7:0]             cooldown_q;
    logic [7:0]             cooldown_d;
    logic signed [7:0]      sin_val;
    logic signed [7:0]      cos_val;
    logic signed [8:0]      vx_spawn;
    logic signed [8:0]      vy_spawn;
    logic [NUM_BULLETS-1:0] valid_vec;
    logic [NUM_BULLETS-1:0] free_vec;
    logic [NUM_BULLETS-1:0] spawn_sel;

    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        assign key_hit[gi] = (bus.keycode[gi*8 +: 8] == FIRE_KEY);
    end

    assign fire  = |key_hit;
    assign press = fire & ~fire_prev_q;

    trig_lut u_trig (
        .angle_i (bus.ShipAngle),
        .sin_o   (sin_val),
        .cos_o   (cos_val)
    );

    assign vx_spawn = scale_velocity(sin_val, BULLET_SPEED, 1'b0);
    assign vy_spawn = scale_velocity(cos_val, BULLET_SPEED, 1'b1);

    // Lowest free slot as a one-hot mask; a slot retiring this edge is not free yet
    assign free_vec  = ~valid_vec;
    assign spawn_sel = free_vec & (~free_vec + NUM_BULLETS'(1));
    assign spawn     = press && (cooldown_q == 8'd0) && (|free_vec);

    always_comb begin
        cooldown_d = cooldown_q;
        if (spawn) begin
            cooldown_d = 8'(COOLDOWN);
        end else if (cooldown_q != 8'd0) begin
            cooldown_d = cooldown_q - 8'd1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            fire_prev_q <= 1'b1;
            cooldown_q  <= 8'd0;
            shot_q      <= 1'b0;
        end else begin
            fire_prev_q <= fire;
            cooldown_q  <= cooldown_d;
            shot_q      <= spawn;
        end
    end

    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
        bullet_t           slot_q;
        bullet_t           slot_d;
        logic signed [14:0] sum_x;
        logic signed [14:0] sum_y;
        logic              off_screen;

        always_comb begin
            sum_x      = $signed({1'b0, slot_q.x_fp}) + 15'($signed(slot_q.vx));
            sum_y      = $signed({1'b0, slot_q.y_fp}) + 15'($signed(slot_q.vy));
            off_screen = sum_x[14] || sum_y[14] ||
                         (sum_x[13:FRAC_BITS] > 10'(X_MAX)) ||
                         (sum_y[13:FRAC_BITS] > 10'(Y_MAX));
            slot_d     = slot_q;
            if (spawn && spawn_sel[gi]) begin
                slot_d.valid = 1'b1;
                slot_d.x_fp  = {bus.ShipX, {FRAC_BITS{1'b0}}};
                slot_d.y_fp  = {bus.ShipY, {FRAC_BITS{1'b0}}};
                slot_d.vx    = vx_spawn;
                slot_d.vy    = vy_spawn;
                slot_d.life  = 8'(LIFETIME);
            end else if (slot_q.valid) begin
                // Retiring slots keep their last on-screen position
                if (slot_q.life == 8'd1 || off_screen) begin
                    slot_d.valid = 1'b0;
                end else begin
                    slot_d.x_fp = sum_x[13:0];
                    slot_d.y_fp = sum_y[13:0];
                    slot_d.life = slot_q.life - 8'd1;
                end
            end
        end

        always_ff @(posedge frame_clk) begin
            if (!Reset_n) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign valid_vec[gi]            = slot_q.valid;
        assign bus.BulletX[gi*10 +: 10] = slot_q.x_fp[13:FRAC_BITS];
        assign bus.BulletY[gi*10 +: 10] = slot_q.y_fp[13:FRAC_BITS];
    end

    assign bus.BulletValid = valid_vec;
    assign bus.ShotFired   = shot_q;
endmodule

// File: tb/tb_bullet_manager.sv
// Directed bench for bullet_manager: spawn, motion, expiry, cooldown, slot use, reset.
module tb_bullet_manager;
    localparam logic [63:0] SPACE = 64'h0000_2C00_0000_0000;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;
    int   checks    = 0;
    int   fails     = 0;

    bullet_manager_if #(.NUM_BULLETS(4)) bus ();

    bullet_manager #(
        .NUM_BULLETS (4),
        .BULLET_SPEED(4),
        .LIFETIME    (60),
        .COOLDOWN    (8),
        .FIRE_KEY    (8'h2C),
        .X_MAX       (639),
        .Y_MAX       (479)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [9:0] slot_x(input int i);
        return bus.BulletX[i*10 +: 10];
    endfunction

    function automatic logic [9:0] slot_y(input int i);
        return bus.BulletY[i*10 +: 10];
    endfunction

    task automatic do_reset(input logic [9:0] sx, input logic [9:0] sy, input logic [5:0] ang);
        bus.ShipX     = sx;
        bus.ShipY     = sy;
        bus.ShipAngle = ang;
        bus.keycode   = 64'd0;
        Reset_n       = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.keycode = SPACE;
        Reset_n     = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.BulletValid !== 4'b0000 || bus.ShotFired !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b shot=%b want valid=0000 shot=0", bus.BulletValid, bus.ShotFired);
        end
        checks++;
        if (bus.BulletX !== 40'd0 || bus.BulletY !== 40'd0) begin
            fails++;
            $display("FAIL reset_pos: X=%h Y=%h want 0", bus.BulletX, bus.BulletY);
        end
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.BulletValid !== 4'b0000 || bus.ShotFired !== 1'b0) begin
            fails++;
            $display("FAIL reset_held_key: valid=%b shot=%b want no spawn", bus.BulletValid, bus.ShotFired);
        end
        bus.keycode = 64'd0;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_straight_up();
        do_reset(10'd320, 10'd240, 6'd0);
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.BulletValid[0] !== 1'b1 || slot_x(0) !== 10'd320 || slot_y(0) !== 10'd240 || bus.ShotFired !== 1'b1) begin
            fails++;
            $display("FAIL up_spawn: v=%b x=%0d y=%0d shot=%b want 1,320,240,1", bus.BulletValid[0], slot_x(0), slot_y(0), bus.ShotFired);
        end
        tick();
        checks++;
        if (bus.ShotFired !== 1'b0 || slot_y(0) !== 10'd236) begin
            fails++;
            $display("FAIL up_first_move: shot=%b y=%0d want 0,236", bus.ShotFired, slot_y(0));
        end
        for (int k = 0; k < 9; k++) tick();
        checks++;
        if (slot_x(0) !== 10'd320 || slot_y(0) !== 10'd200 || bus.BulletValid !== 4'b0001) begin
            fails++;
            $display("FAIL up_10_frames: x=%0d y=%0d v=%b want 320,200,0001", slot_x(0), slot_y(0), bus.BulletValid);
        end
        $display("[TB] test_straight_up done y=%0d", slot_y(0));
    endtask

    task automatic test_right_edge();
        logic [9:0] exp_x [3];
        exp_x[0] = 10'd630;
        exp_x[1] = 10'd634;
        exp_x[2] = 10'd638;
        do_reset(10'd630, 10'd100, 6'd16);
        bus.keycode = SPACE;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.keycode = 64'd0;
            checks++;
            if (bus.BulletValid[0] !== 1'b1 || slot_x(0) !== exp_x[k] || slot_y(0) !== 10'd100) begin
                fails++;
                $display("FAIL edge_step%0d: v=%b x=%0d y=%0d want 1,%0d,100", k, bus.BulletValid[0], slot_x(0), slot_y(0), exp_x[k]);
            end
        end
        tick();
        checks++;
        if (bus.BulletValid[0] !== 1'b0) begin
            fails++;
            $display("FAIL edge_exit: v=%b want 0", bus.BulletValid[0]);
        end
        $display("[TB] test_right_edge done");
    endtask

    task automatic test_diagonal_lifetime();
        int live;
        do_reset(10'd320, 10'd240, 6'd8);
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        live = (bus.BulletValid[0] === 1'b1) ? 1 : 0;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if (slot_x(0) !== 10'd322 || slot_y(0) !== 10'd237) begin
                    fails++;
                    $display("FAIL diag_move1: x=%0d y=%0d want 322,237", slot_x(0), slot_y(0));
                end
            end
            if (k == 16) begin
                checks++;
                if (slot_x(0) !== 10'd365 || slot_y(0) !== 10'd195) begin
                    fails++;
                    $display("FAIL diag_move16: x=%0d y=%0d want 365,195", slot_x(0), slot_y(0));
                end
            end
            if (bus.BulletValid[0] === 1'b1) live++;
            else break;
        end
        checks++;
        if (live != 60) begin
            fails++;
            $display("FAIL diag_lifetime: live=%0d want 60", live);
        end
        $display("[TB] test_diagonal_lifetime done live=%0d", live);
    endtask

    task automatic test_hold_and_cooldown();
        int shots;
        do_reset(10'd320, 10'd240, 6'd0);
        shots = 0;
        bus.keycode = SPACE;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.ShotFired === 1'b1) shots++;
        end
        bus.keycode = 64'd0;
        tick();
        checks++;
        if (shots != 1) begin
            fails++;
            $display("FAIL hold_one_shot: shots=%0d want 1", shots);
        end
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        tick();
        tick();
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.ShotFired !== 1'b0 || bus.BulletValid !== 4'b0001) begin
            fails++;
            $display("FAIL cooldown_drop: shot=%b v=%b want 0,0001", bus.ShotFired, bus.BulletValid);
        end
        for (int k = 0; k < 5; k++) tick();
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.ShotFired !== 1'b1 || bus.BulletValid !== 4'b0011) begin
            fails++;
            $display("FAIL cooldown_expired: shot=%b v=%b want 1,0011", bus.ShotFired, bus.BulletValid);
        end
        tick();
        $display("[TB] test_hold_and_cooldown done shots=%0d", shots);
    endtask

    task automatic test_fill_slots();
        logic [3:0] exp_v;
        do_reset(10'd320, 10'd240, 6'd0);
        for (int p = 0; p < 4; p++) begin
            exp_v = 4'((1 << (p + 1)) - 1);
            bus.keycode = SPACE;
            tick();
            bus.keycode = 64'd0;
            checks++;
            if (bus.ShotFired !== 1'b1 || bus.BulletValid !== exp_v) begin
                fails++;
                $display("FAIL fill_press%0d: shot=%b v=%b want 1,%b", p, bus.ShotFired, bus.BulletValid, exp_v);
            end
            for (int k = 0; k < 8; k++) tick();
        end
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.ShotFired !== 1'b0 || bus.BulletValid !== 4'b1111) begin
            fails++;
            $display("FAIL fill_full: shot=%b v=%b want 0,1111", bus.ShotFired, bus.BulletValid);
        end
        for (int k = 0; k < 24; k++) tick();
        checks++;
        if (bus.BulletValid !== 4'b1110) begin
            fails++;
            $display("FAIL fill_slot0_expired: v=%b want 1110", bus.BulletValid);
        end
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.ShotFired !== 1'b1 || bus.BulletValid !== 4'b1111 || slot_y(0) !== 10'd240) begin
            fails++;
            $display("FAIL fill_reuse0: shot=%b v=%b y0=%0d want 1,1111,240", bus.ShotFired, bus.BulletValid, slot_y(0));
        end
        $display("[TB] test_fill_slots done");
    endtask

    task automatic test_reset_midflight();
        do_reset(10'd320, 10'd240, 6'd0);
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        for (int k = 0; k < 8; k++) tick();
        bus.keycode = SPACE;
        tick();
        checks++;
        if (bus.BulletValid !== 4'b0011) begin
            fails++;
            $display("FAIL mid_two_live: v=%b want 0011", bus.BulletValid);
        end
        bus.keycode = 64'd0;
        tick();
        bus.keycode = SPACE;
        Reset_n     = 1'b0;
        tick();
        Reset_n = 1'b1;
        checks++;
        if (bus.BulletValid !== 4'b0000 || bus.ShotFired !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_clear: v=%b shot=%b want 0000,0", bus.BulletValid, bus.ShotFired);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.BulletValid !== 4'b0000) begin
            fails++;
            $display("FAIL mid_held_no_spawn: v=%b want 0000", bus.BulletValid);
        end
        bus.keycode = 64'd0;
        tick();
        bus.keycode = SPACE;
        tick();
        bus.keycode = 64'd0;
        checks++;
        if (bus.ShotFired !== 1'b1 || bus.BulletValid !== 4'b0001) begin
            fails++;
            $display("FAIL mid_repress: shot=%b v=%b want 1,0001", bus.ShotFired, bus.BulletValid);
        end
        $display("[TB] test_reset_midflight done");
    endtask

    initial begin
        bus.keycode   = 64'd0;
        bus.ShipX     = 10'd0;
        bus.ShipY     = 10'd0;
        bus.ShipAngle = 6'd0;
        test_reset();
        test_straight_up();
        test_right_edge();
        test_diagonal_lifetime();
        test_hold_and_cooldown();
        test_fill_slots();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule
